// File: rtl/param_decoder_pkg.sv
// rtl/param_decoder_pkg.sv - shared constants and binary-to-one-hot helper for param_decoder
package param_decoder_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int MAX_WIDTH     = 8;

    // Select bits above 'width' are ignored so callers may pass a zero-padded select.
    function automatic logic [(1 << MAX_WIDTH)-1:0] onehot_decode(
        input logic [MAX_WIDTH-1:0] sel,
        input int unsigned          width
    );
        logic [(1 << MAX_WIDTH)-1:0] v;
        logic [MAX_WIDTH-1:0]        s;
        s = sel;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i >= int'(width)) begin
                s[i] = 1'b0;
            end
        end
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/param_decoder_core.sv
// rtl/param_decoder_core.sv - combinational binary-to-one-hot decode with output polarity select
module param_decoder_core
    import param_decoder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [WIDTH-1:0]        i_sel,
    output logic [(1 << WIDTH)-1:0] o_y
);

    localparam int N = 1 << WIDTH;

    logic [MAX_WIDTH-1:0] w_sel_ext;
    logic [N-1:0]         w_onehot;

    always_comb begin
        w_sel_ext              = '0;
        w_sel_ext[WIDTH-1:0]   = i_sel;
    end

    assign w_onehot = N'(onehot_decode(w_sel_ext, WIDTH));
    assign o_y      = ACTIVE_LOW ? ~w_onehot : w_onehot;

endmodule

// File: rtl/param_decoder.sv
// rtl/param_decoder.sv - registered one-hot decoder; PARAM_DECODER_ONEHOT_CHECK_EN adds sim checks
module param_decoder
    import param_decoder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [WIDTH-1:0]        a,
    output logic [(1 << WIDTH)-1:0] y,
    output logic                    valid
);

    localparam int           N    = 1 << WIDTH;
    localparam logic [N-1:0] IDLE = {N{ACTIVE_LOW}};

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("param_decoder: WIDTH must be within 1..8");
    end

    logic [N-1:0] w_dec;
    logic [N-1:0] r_y;
    logic         r_valid;

    param_decoder_core #(
        .WIDTH      (WIDTH),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_core (
        .i_sel (a),
        .o_y   (w_dec)
    );

    // Reset outranks enable, so a decode presented on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y     <= IDLE;
            r_valid <= 1'b0;
        end else if (en) begin
            r_y     <= w_dec;
            r_valid <= 1'b1;
        end else begin
            r_y     <= IDLE;
            r_valid <= 1'b0;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;

`ifdef PARAM_DECODER_ONEHOT_CHECK_EN
    logic [WIDTH-1:0] r_prev_a;
    logic             r_prev_live;
    logic [N-1:0]     w_active;

    // XOR with IDLE gives an active-high view regardless of polarity.
    assign w_active = r_y ^ IDLE;

    always_ff @(posedge clk) begin
        r_prev_a    <= a;
        r_prev_live <= rst_n & en;
    end

    always @(posedge clk) begin
        if (r_valid === 1'b1 && !$onehot(w_active)) begin
            $error("param_decoder: y not one-hot while valid");
        end
        if (r_valid === 1'b0 && r_y !== IDLE) begin
            $error("param_decoder: y not idle while not valid");
        end
        if (r_prev_live === 1'b1 && w_active !== (N'(1) << r_prev_a)) begin
            $error("param_decoder: active bit does not match previous select");
        end
    end
`endif

endmodule

// File: tb/tb_param_decoder.sv
// tb/tb_param_decoder.sv - directed self-checking bench for param_decoder in three configurations
module tb_param_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  a3;
    logic [3:0]  a4;
    logic [7:0]  y_hi;
    logic        v_hi;
    logic [7:0]  y_lo;
    logic        v_lo;
    logic [15:0] y_w4;
    logic        v_w4;

    int n_checks = 0;
    int n_errors = 0;

    param_decoder dut_hi (
        .clk (clk), .rst_n (rst_n), .en (en), .a (a3), .y (y_hi), .valid (v_hi)
    );

    param_decoder #(.WIDTH(3), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk (clk), .rst_n (rst_n), .en (en), .a (a3), .y (y_lo), .valid (v_lo)
    );

    param_decoder #(.WIDTH(4), .ACTIVE_LOW(1'b0)) dut_w4 (
        .clk (clk), .rst_n (rst_n), .en (en), .a (a4), .y (y_w4), .valid (v_w4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_hi [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] exp_lo [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        a3    = 3'd3;
        a4    = 4'd0;
        step();
        step();
        check("reset_y_hi",  16'(y_hi), 16'h0000);
        check("reset_v_hi",  16'(v_hi), 16'h0000);
        check("reset_y_lo",  16'(y_lo), 16'h00FF);
        check("reset_v_lo",  16'(v_lo), 16'h0000);
        check("reset_y_w4",  y_w4,      16'h0000);

        rst_n = 1'b1;
        step();
        check("release_y_hi", 16'(y_hi), 16'h0008);
        check("release_v_hi", 16'(v_hi), 16'h0001);

        for (int i = 0; i < 8; i++) begin
            a3 = 3'(i);
            step();
            check($sformatf("sweep_hi_a%0d", i), 16'(y_hi), 16'(exp_hi[i]));
            check($sformatf("sweep_lo_a%0d", i), 16'(y_lo), 16'(exp_lo[i]));
            check($sformatf("sweep_v_a%0d", i),  16'(v_hi), 16'h0001);
        end

        a3 = 3'b101;
        step();
        check("a5_y_hi", 16'(y_hi), 16'h0020);

        a3 = 3'd6;
        en = 1'b1;
        step();
        check("en1_y_hi", 16'(y_hi), 16'h0040);
        en = 1'b0;
        step();
        check("en0_y_hi", 16'(y_hi), 16'h0000);
        check("en0_v_hi", 16'(v_hi), 16'h0000);
        check("en0_y_lo", 16'(y_lo), 16'h00FF);
        check("en0_v_lo", 16'(v_lo), 16'h0000);
        en = 1'b1;
        step();
        check("en1b_y_hi", 16'(y_hi), 16'h0040);
        check("en1b_v_hi", 16'(v_hi), 16'h0001);

        a3 = 3'd2;
        step();
        check("lo_a2_y", 16'(y_lo), 16'h00FB);
        check("lo_a2_v", 16'(v_lo), 16'h0001);

        a4 = 4'd15;
        step();
        check("w4_a15_y", y_w4, 16'h8000);
        check("w4_a15_v", 16'(v_w4), 16'h0001);
        a4 = 4'd0;
        step();
        check("w4_a0_y", y_w4, 16'h0001);
        check("w4_a0_v", 16'(v_w4), 16'h0001);
        a4 = 4'd9;
        step();
        check("w4_a9_y", y_w4, 16'h0200);

        a3 = 3'd1;
        step();
        check("pre_rst_y_hi", 16'(y_hi), 16'h0002);
        a3    = 3'd7;
        rst_n = 1'b0;
        step();
        check("midrst_y_hi", 16'(y_hi), 16'h0000);
        check("midrst_v_hi", 16'(v_hi), 16'h0000);
        check("midrst_y_lo", 16'(y_lo), 16'h00FF);
        check("midrst_y_w4", y_w4,      16'h0000);
        rst_n = 1'b1;
        step();
        check("post_rst_y_hi", 16'(y_hi), 16'h0080);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
